// File: rtl/nexus_nonce_scheduler.sv
// Nonce scheduler for the Nexus Keccak-1024 mining pipeline: issues header/nonce pairs,
// tracks them through a matching delay line and hands target hits to the host.
module nexus_nonce_scheduler #(
  parameter int unsigned PIPE_LATENCY = 72,
  parameter int unsigned NONCE_LSB    = 960
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic [1023:0] WorkIn,
  input  logic [63:0]   StartNonce,
  input  logic [63:0]   NonceCount,
  input  logic [63:0]   Target,
  input  logic          Stop,
  output logic [1023:0] PipeIn,
  input  logic [63:0]   PipeOut,
  output logic          Busy,
  output logic          Done,
  output logic          FoundValid,
  input  logic          FoundReady,
  output logic [63:0]   FoundNonce,
  output logic          Overflow
);

  localparam int unsigned HDR_W   = 1024;
  localparam int unsigned NONCE_W = 64;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 w_start;
  logic                 w_issue;
  logic                 w_done;
  logic                 w_inflight;
  logic                 w_hit;
  logic [HDR_W-1:0]     w_hdr;

  logic [HDR_W-1:0]     r_work;
  logic [NONCE_W-1:0]   r_target;
  logic [NONCE_W-1:0]   r_next;
  logic [NONCE_W-1:0]   r_remain;
  logic [HDR_W-1:0]     r_pipe_in;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_iss_v;
  logic [NONCE_W-1:0]   r_iss_n;
  logic [PIPE_LATENCY-1:0] r_dl_v;
  logic [NONCE_W-1:0]   r_dl_n [PIPE_LATENCY];
  logic                 r_fv;
  logic [NONCE_W-1:0]   r_fn;
  logic                 r_ovf;

  // r_iss_* travels with PipeIn; the delay line samples it on the same edge the pipeline does
  assign w_inflight = r_iss_v | (|r_dl_v);
  assign w_hit      = r_dl_v[PIPE_LATENCY-1] && (PipeOut <= r_target);

  always_comb begin
    w_hdr = r_work;
    w_hdr[NONCE_LSB +: NONCE_W] = r_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_issue    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_start    = 1'b1;
          w_state_nx = (NonceCount != '0) ? S_ISSUE : S_DRAIN;
        end
      end
      S_ISSUE: begin
        if (Stop) begin
          w_state_nx = S_DRAIN;
        end else begin
          w_issue = (r_remain != '0);
          if (r_remain <= NONCE_W'(1)) w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_inflight) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_target  <= '0;
      r_next    <= '0;
      r_remain  <= '0;
      r_pipe_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_iss_v   <= 1'b0;
      r_iss_n   <= '0;
      r_dl_v    <= '0;
    end else begin
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= w_done;
      r_iss_v <= w_issue;
      r_iss_n <= r_next;
      r_dl_v  <= {r_dl_v[PIPE_LATENCY-2:0], r_iss_v};
      if (w_start) begin
        r_work   <= WorkIn;
        r_target <= Target;
        r_next   <= StartNonce;
        r_remain <= NonceCount;
      end else if (w_issue) begin
        r_pipe_in <= w_hdr;
        r_next    <= r_next + NONCE_W'(1);
        r_remain  <= r_remain - NONCE_W'(1);
      end
    end
  end

  // Nonce payloads carry no reset; the valid bits alone decide what is live
  always_ff @(posedge clk) begin
    r_dl_n[0] <= r_iss_n;
    for (int i = 1; i < int'(PIPE_LATENCY); i++) r_dl_n[i] <= r_dl_n[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fv  <= 1'b0;
      r_fn  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_start) r_ovf <= 1'b0;
      if (w_hit) begin
        if (!r_fv || FoundReady) begin
          r_fv <= 1'b1;
          r_fn <= r_dl_n[PIPE_LATENCY-1];
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_fv && FoundReady) begin
        r_fv <= 1'b0;
      end
    end
  end

  assign PipeIn     = r_pipe_in;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign FoundValid = r_fv;
  assign FoundNonce = r_fn;
  assign Overflow   = r_ovf;

endmodule
